// File: rtl/fwd_scoreboard_unit_pkg.sv
// Shared widths, select encodings and helpers for the forwarding/scoreboard unit.
package fwd_scoreboard_unit_pkg;

    localparam int unsigned NumRegsDef   = 32;
    localparam int unsigned AwDef        = 5;
    localparam int unsigned NumSrcDef    = 2;
    localparam int unsigned FwdStagesDef = 2;
    localparam int unsigned LwDef        = 3;
    localparam int unsigned SwDef        = 2;

    // Select code meaning "take the operand from the register file".
    localparam int unsigned FwdSelRf     = 0;

    // Stage indices as seen by the EX operand muxes.
    localparam int unsigned FwdStgExMem  = 0;
    localparam int unsigned FwdStgMemWb  = 1;

    typedef enum logic [SwDef-1:0] {
        SelRf    = 2'd0,
        SelExMem = 2'd1,
        SelMemWb = 2'd2
    } fwd_sel_e;

    // Select code for a hit in downstream stage 'stage'.
    function automatic int unsigned stage_sel(input int unsigned stage);
        return stage + 1;
    endfunction

endpackage

// File: rtl/fwd_scoreboard_unit_if.sv
// ID/EX-side bundle for the forwarding/scoreboard unit: issue request, EX sources,
// downstream writeback tags and the unit's select/stall outputs.
interface fwd_scoreboard_unit_if
    import fwd_scoreboard_unit_pkg::*;
#(
    parameter int unsigned AW         = AwDef,
    parameter int unsigned NUM_SRC    = NumSrcDef,
    parameter int unsigned FWD_STAGES = FwdStagesDef,
    parameter int unsigned LW         = LwDef,
    parameter int unsigned SW         = SwDef
);

    logic                        issue_valid;
    logic                        issue_we;
    logic [AW-1:0]               issue_rd;
    logic [LW-1:0]               issue_lat;
    logic [NUM_SRC*AW-1:0]       issue_rs;
    logic [NUM_SRC-1:0]          issue_rs_use;
    logic                        flush;
    logic [NUM_SRC*AW-1:0]       ex_rs;
    logic [FWD_STAGES-1:0]       stg_we;
    logic [FWD_STAGES*AW-1:0]    stg_rd;
    logic [NUM_SRC*SW-1:0]       fwd_sel;
    logic                        stall;
    logic [31:0]                 stall_cnt;

    // Pipeline control side.
    modport master (
        output issue_valid, issue_we, issue_rd, issue_lat, issue_rs, issue_rs_use, flush,
        output ex_rs, stg_we, stg_rd,
        input  fwd_sel, stall, stall_cnt
    );

    // Forwarding/scoreboard unit side.
    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_lat, issue_rs, issue_rs_use, flush,
        input  ex_rs, stg_we, stg_rd,
        output fwd_sel, stall, stall_cnt
    );

endinterface

// File: rtl/fwd_scoreboard_unit_prio_sel.sv
// Priority encoder: one EX source against all forwardable stages, youngest match wins.
module fwd_prio_sel
    import fwd_scoreboard_unit_pkg::*;
#(
    parameter int unsigned AW         = AwDef,
    parameter int unsigned FWD_STAGES = FwdStagesDef,
    parameter int unsigned SW         = SwDef
) (
    input  logic [AW-1:0]            rs_i,
    input  logic [FWD_STAGES-1:0]    stg_we_i,
    input  logic [FWD_STAGES*AW-1:0] stg_rd_i,
    output logic [SW-1:0]            sel_o
);

    always_comb begin
        sel_o = SW'(FwdSelRf);
        // Walk oldest to youngest so the youngest match is written last and wins.
        for (int s = int'(FWD_STAGES) - 1; s >= 0; s--) begin
            if (stg_we_i[s] && (stg_rd_i[s*AW +: AW] != '0) &&
                (stg_rd_i[s*AW +: AW] == rs_i)) begin
                sel_o = SW'(stage_sel(unsigned'(s)));
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Operand forwarding selects plus a per-register latency scoreboard that stalls ID
// while a source or destination is still pending from a load or multi-cycle FP op.
module fwd_scoreboard_unit
    import fwd_scoreboard_unit_pkg::*;
#(
    parameter int unsigned NUM_REGS   = NumRegsDef,
    parameter int unsigned AW         = AwDef,
    parameter int unsigned NUM_SRC    = NumSrcDef,
    parameter int unsigned FWD_STAGES = FwdStagesDef,
    parameter int unsigned LW         = LwDef,
    parameter int unsigned SW         = SwDef
) (
    input  logic                  clk,
    input  logic                  reset,
    fwd_scoreboard_unit_if.slave  bus
);

    logic [NUM_SRC*SW-1:0] fwd_sel_w;

    logic [LW-1:0] cnt_q [NUM_REGS];
    logic [LW-1:0] cnt_d [NUM_REGS];
    logic [31:0]   stall_cnt_q;
    logic [31:0]   stall_cnt_d;

    logic [AW-1:0]      src     [NUM_SRC];
    logic [NUM_SRC-1:0] raw_vec;
    logic               raw_hz;
    logic               waw_hz;
    logic               hazard;
    logic               req;
    logic               stall;
    logic               fire;
    logic [LW-1:0]      eff_lat;

    // Forward selects.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_prio_sel #(
            .AW         (AW),
            .FWD_STAGES (FWD_STAGES),
            .SW         (SW)
        ) u_prio_sel (
            .rs_i     (bus.ex_rs[i*AW +: AW]),
            .stg_we_i (bus.stg_we),
            .stg_rd_i (bus.stg_rd),
            .sel_o    (fwd_sel_w[i*SW +: SW])
        );

        assign src[i]     = bus.issue_rs[i*AW +: AW];
        assign raw_vec[i] = bus.issue_rs_use[i] && (src[i] != '0) && (cnt_q[src[i]] != '0);
    end

    assign bus.fwd_sel = fwd_sel_w;

    // max(lat, 1) for nonzero lat is lat itself; lat 0 leaves the register untracked.
    assign eff_lat = bus.issue_lat;

    assign raw_hz = |raw_vec;
    assign waw_hz = bus.issue_we && (bus.issue_rd != '0) && (cnt_q[bus.issue_rd] > eff_lat);
    assign hazard = raw_hz || waw_hz;

    // Reset and flush both mask the request before it can stall or write the scoreboard.
    assign req   = !reset && bus.issue_valid && !bus.flush;
    assign stall = req && hazard;
    assign fire  = req && !hazard && bus.issue_we && (bus.issue_rd != '0);

    assign bus.stall     = stall;
    assign bus.stall_cnt = stall_cnt_q;

    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (fire && (bus.issue_rd == AW'(r))) begin
                cnt_d[r] = eff_lat;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LW'(1);
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // A stalled request never writes the scoreboard.
    assert property (@(posedge clk) disable iff (reset) !(stall && fire));

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Self-checking bench for fwd_scoreboard_unit: scoreboard queue of expected stall,
// select and stall-count values checked against the DUT every cycle, plus scenario checks.
module tb_fwd_scoreboard_unit;

    typedef struct packed {
        logic        stall;
        logic [3:0]  sel;
        logic [31:0] scnt;
    } rec_t;

    logic clk;
    logic reset;

    fwd_scoreboard_unit_if bus ();

    fwd_scoreboard_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned m_cnt [32];
    logic [31:0] m_stall_cnt;
    logic        last_stall;
    rec_t        exp_q [$];
    rec_t        obs_q [$];

    function automatic logic [1:0] ref_sel(input logic [4:0] rs);
        for (int s = 0; s < 2; s++) begin
            if (rs != 5'd0 && bus.stg_we[s] && bus.stg_rd[s*5 +: 5] == rs) return 2'(s + 1);
        end
        return 2'd0;
    endfunction

    task automatic drive(input logic v, input logic we, input int rd, input int lat,
                         input int rs0, input int rs1, input logic [1:0] use_v,
                         input logic fl);
        bus.issue_valid  = v;
        bus.issue_we     = we;
        bus.issue_rd     = 5'(rd);
        bus.issue_lat    = 3'(lat);
        bus.issue_rs     = {5'(rs1), 5'(rs0)};
        bus.issue_rs_use = use_v;
        bus.flush        = fl;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 0, 0, 0, 0, 2'b00, 1'b0);
        for (int k = 0; k < n; k++) clk_step();
    endtask

    // Predicts this cycle from the model, records DUT outputs, advances one edge.
    task automatic clk_step();
        rec_t        e;
        rec_t        o;
        logic        raw;
        logic        waw;
        logic        go;
        int unsigned rd;
        int unsigned rs;
        #1;
        raw = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rs = bus.issue_rs[i*5 +: 5];
            if (bus.issue_rs_use[i] && rs != 0 && m_cnt[rs] != 0) raw = 1'b1;
        end
        rd      = bus.issue_rd;
        waw     = bus.issue_we && rd != 0 && m_cnt[rd] > bus.issue_lat;
        e.stall = !reset && bus.issue_valid && !bus.flush && (raw || waw);
        go      = !reset && bus.issue_valid && !bus.flush && !(raw || waw) &&
                  bus.issue_we && rd != 0;
        e.sel   = {ref_sel(bus.ex_rs[9:5]), ref_sel(bus.ex_rs[4:0])};
        o.stall = bus.stall;
        o.sel   = bus.fwd_sel;
        for (int unsigned r = 1; r < 32; r++) begin
            if (reset)                 m_cnt[r] = 0;
            else if (go && r == rd)    m_cnt[r] = bus.issue_lat;
            else if (m_cnt[r] > 0)     m_cnt[r] = m_cnt[r] - 1;
        end
        if (reset) m_stall_cnt = 32'd0;
        else if (e.stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 32'd1;
        e.scnt = m_stall_cnt;
        @(posedge clk);
        #1;
        o.scnt = bus.stall_cnt;
        exp_q.push_back(e);
        obs_q.push_back(o);
        last_stall = o.stall;
    endtask

    // Steps until the held instruction stops stalling; a blown bound reports 16.
    task automatic run_until_issue(output int stalls);
        stalls = 0;
        for (int k = 0; k < 16; k++) begin
            clk_step();
            if (last_stall !== 1'b1) return;
            stalls++;
        end
    endtask

    task automatic test_reset();
        rec_t e, o;
        reset = 1'b1;
        drive(1'b1, 1'b1, 3, 4, 3, 3, 2'b11, 1'b0);
        clk_step();
        clk_step();
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b, expected 0", bus.stall);
        end
        n_checks++;
        if (bus.stall_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_stall_cnt: got %h, expected 0", bus.stall_cnt);
        end
        reset = 1'b0;
        idle(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sb_reset: got stall=%b sel=%h cnt=%h, expected stall=%b sel=%h cnt=%h",
                         o.stall, o.sel, o.scnt, e.stall, e.sel, e.scnt);
            end
        end
    endtask

    task automatic test_forward();
        rec_t e, o;
        idle(0);
        bus.ex_rs = {5'd5, 5'd5}; bus.stg_we = 2'b11; bus.stg_rd = {5'd5, 5'd5};
        clk_step();
        n_checks++;
        if (bus.fwd_sel[1:0] !== 2'd1) begin
            n_fail++; $display("FAIL fwd_youngest: got %0d, expected 1", bus.fwd_sel[1:0]);
        end
        bus.stg_we = 2'b10;
        clk_step();
        n_checks++;
        if (bus.fwd_sel[1:0] !== 2'd2) begin
            n_fail++; $display("FAIL fwd_older: got %0d, expected 2", bus.fwd_sel[1:0]);
        end
        bus.ex_rs = {5'd0, 5'd0}; bus.stg_we = 2'b11; bus.stg_rd = {5'd0, 5'd0};
        clk_step();
        n_checks++;
        if (bus.fwd_sel !== 4'd0) begin
            n_fail++; $display("FAIL fwd_zero: got %h, expected 0", bus.fwd_sel);
        end
        bus.ex_rs = {5'd7, 5'd5}; bus.stg_rd = {5'd7, 5'd5};
        clk_step();
        n_checks++;
        if (bus.fwd_sel !== 4'b1001) begin
            n_fail++; $display("FAIL fwd_split: got %b, expected 1001", bus.fwd_sel);
        end
        for (int k = 0; k < 24; k++) begin
            bus.ex_rs  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            bus.stg_we = 2'($urandom_range(0, 3));
            bus.stg_rd = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            clk_step();
        end
        bus.ex_rs = '0; bus.stg_we = '0; bus.stg_rd = '0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sb_forward: got stall=%b sel=%h cnt=%h, expected stall=%b sel=%h cnt=%h",
                         o.stall, o.sel, o.scnt, e.stall, e.sel, e.scnt);
            end
        end
    endtask

    task automatic test_load_use();
        rec_t e, o;
        int   n;
        reset = 1'b1; idle(1); reset = 1'b0;
        drive(1'b1, 1'b1, 8, 1, 0, 0, 2'b00, 1'b0);
        clk_step();
        drive(1'b1, 1'b1, 10, 0, 8, 0, 2'b01, 1'b0);
        run_until_issue(n);
        n_checks++;
        if (n !== 1) begin
            n_fail++; $display("FAIL load_use_bubbles: got %0d, expected 1", n);
        end
        n_checks++;
        if (bus.stall_cnt !== 32'd1) begin
            n_fail++; $display("FAIL load_use_stall_cnt: got %0d, expected 1", bus.stall_cnt);
        end
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sb_load_use: got stall=%b sel=%h cnt=%h, expected stall=%b sel=%h cnt=%h",
                         o.stall, o.sel, o.scnt, e.stall, e.sel, e.scnt);
            end
        end
    endtask

    task automatic test_fp_raw();
        rec_t e, o;
        int   n;
        drive(1'b1, 1'b1, 3, 4, 0, 0, 2'b00, 1'b0);
        clk_step();
        drive(1'b1, 1'b0, 0, 0, 1, 3, 2'b10, 1'b0);
        run_until_issue(n);
        // Counter holds 4, 3, 2, 1 on the following cycles.
        n_checks++;
        if (n !== 4) begin
            n_fail++; $display("FAIL fp_raw_stalls: got %0d, expected 4", n);
        end
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sb_fp_raw: got stall=%b sel=%h cnt=%h, expected stall=%b sel=%h cnt=%h",
                         o.stall, o.sel, o.scnt, e.stall, e.sel, e.scnt);
            end
        end
    endtask

    task automatic test_waw();
        rec_t e, o;
        int   n;
        drive(1'b1, 1'b1, 6, 5, 0, 0, 2'b00, 1'b0);
        clk_step();
        drive(1'b1, 1'b1, 6, 1, 0, 0, 2'b00, 1'b0);
        run_until_issue(n);
        n_checks++;
        if (n !== 4) begin
            n_fail++; $display("FAIL waw_short_stalls: got %0d, expected 4", n);
        end
        idle(8);
        drive(1'b1, 1'b1, 6, 5, 0, 0, 2'b00, 1'b0);
        clk_step();
        drive(1'b1, 1'b1, 6, 7, 0, 0, 2'b00, 1'b0);
        run_until_issue(n);
        n_checks++;
        if (n !== 0) begin
            n_fail++; $display("FAIL waw_long_stalls: got %0d, expected 0", n);
        end
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sb_waw: got stall=%b sel=%h cnt=%h, expected stall=%b sel=%h cnt=%h",
                         o.stall, o.sel, o.scnt, e.stall, e.sel, e.scnt);
            end
        end
    endtask

    task automatic test_flush();
        rec_t e, o;
        int   n;
        drive(1'b1, 1'b1, 4, 6, 0, 0, 2'b00, 1'b0);
        clk_step();
        drive(1'b1, 1'b1, 12, 5, 4, 0, 2'b01, 1'b1);
        #1;
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_mask: got %b, expected 0", bus.stall);
        end
        clk_step();
        drive(1'b1, 1'b0, 0, 0, 12, 0, 2'b01, 1'b0);
        #1;
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_write: got %b, expected 0", bus.stall);
        end
        clk_step();
        // r4 kept counting through the flush: 6 -> 5 -> 4.
        drive(1'b1, 1'b0, 0, 0, 0, 4, 2'b10, 1'b0);
        run_until_issue(n);
        n_checks++;
        if (n !== 4) begin
            n_fail++; $display("FAIL flush_inflight: got %0d, expected 4", n);
        end
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sb_flush: got stall=%b sel=%h cnt=%h, expected stall=%b sel=%h cnt=%h",
                         o.stall, o.sel, o.scnt, e.stall, e.sel, e.scnt);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        rec_t e, o;
        int   n;
        drive(1'b1, 1'b1, 3, 7, 0, 0, 2'b00, 1'b0);
        clk_step();
        idle(4);
        reset = 1'b1;
        drive(1'b1, 1'b0, 0, 0, 3, 0, 2'b01, 1'b0);
        #1;
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_masks_stall: got %b, expected 0", bus.stall);
        end
        clk_step();
        reset = 1'b0;
        run_until_issue(n);
        n_checks++;
        if (n !== 0) begin
            n_fail++; $display("FAIL reset_discards: got %0d stalls, expected 0", n);
        end
        idle(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sb_reset_mid: got stall=%b sel=%h cnt=%h, expected stall=%b sel=%h cnt=%h",
                         o.stall, o.sel, o.scnt, e.stall, e.sel, e.scnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        rec_t e, o;
        for (int k = 0; k < 60; k++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0));
            clk_step();
        end
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sb_back_to_back: got stall=%b sel=%h cnt=%h, expected stall=%b sel=%h cnt=%h",
                         o.stall, o.sel, o.scnt, e.stall, e.sel, e.scnt);
            end
        end
    endtask

    task automatic test_saturation();
        rec_t e, o;
        drive(1'b1, 1'b1, 9, 7, 0, 0, 2'b00, 1'b0);
        clk_step();
        drive(1'b1, 1'b0, 0, 0, 9, 0, 2'b01, 1'b0);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_stall_cnt = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            clk_step();
            n_checks++;
            if (bus.stall_cnt !== 32'hFFFF_FFFF || last_stall !== 1'b1) begin
                n_fail++;
                $display("FAIL saturate: got cnt=%h stall=%b, expected cnt=ffffffff stall=1",
                         bus.stall_cnt, last_stall);
            end
        end
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sb_saturate: got stall=%b sel=%h cnt=%h, expected stall=%b sel=%h cnt=%h",
                         o.stall, o.sel, o.scnt, e.stall, e.sel, e.scnt);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_stall_cnt = 32'd0;
        last_stall  = 1'b0;
        reset       = 1'b1;
        bus.ex_rs   = '0;
        bus.stg_we  = '0;
        bus.stg_rd  = '0;
        drive(1'b0, 1'b0, 0, 0, 0, 0, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_forward();
        test_load_use();
        test_fp_raw();
        test_waw();
        test_flush();
        test_reset_mid_op();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
